// File: rtl/dmem_access_unit_if.sv
// Word-wide data-memory bus between the access unit (master) and memory (slave).
// One transfer completes on any cycle with dmem_req and dmem_ready both high.
interface dmem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// M-stage load/store unit: latches one access, runs a single bus transfer, formats load data.
// Accept-to-load_valid is 2 cycles minimum; stall holds the pipeline until dmem_ready or timeout.
module dmem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid,
  input  logic                      mem_we,
  input  logic [2:0]                LdSel,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic                      stall,
  output logic [31:0]               load_data,
  output logic                      load_valid,
  output logic                      misalign,
  output logic                      bus_err,
  dmem_access_unit_if.master        dmem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [7:0]  wait_cnt;
  logic        we_q;
  logic [2:0]  ldsel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        timeout_q;

  logic        code_ok;
  logic        aligned;
  logic        accept;
  logic        in_bus;
  logic        xfer_done;
  logic        timeout;
  logic [15:0] rd_lane;
  logic [31:0] load_fmt;

  always_comb begin
    case (LdSel)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: code_ok = 1'b1;
      default:                                code_ok = 1'b0;
    endcase
    case (LdSel[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign accept    = (state == IDLE) && mem_valid && code_ok && aligned;
  assign misalign  = (state == IDLE) && mem_valid && !(code_ok && aligned);
  assign in_bus    = (state == REQ) || (state == WAIT);
  assign xfer_done = in_bus && dmem.dmem_ready;
  // The last permitted WAIT cycle still completes if ready arrives in it.
  assign timeout   = (state == WAIT) && !dmem.dmem_ready && (wait_cnt == LAST_WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     state_nxt = dmem.dmem_ready ? DONE : WAIT;
      WAIT:    if (dmem.dmem_ready || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      we_q      <= 1'b0;
      ldsel_q   <= 3'b000;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      timeout_q <= 1'b0;
      load_data <= 32'd0;
    end else begin
      state     <= state_nxt;
      timeout_q <= timeout;
      if (accept) begin
        we_q    <= mem_we;
        ldsel_q <= LdSel;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (accept) begin
        wait_cnt <= 8'd0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (xfer_done && !we_q) begin
        load_data <= load_fmt;
      end else if (timeout) begin
        load_data <= 32'd0;
      end
    end
  end

  assign dmem.dmem_req  = in_bus;
  assign dmem.dmem_we   = in_bus && we_q;
  assign dmem.dmem_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    case (ldsel_q[1:0])
      2'b00:   dmem.dmem_wdata = {4{wdata_q[7:0]}};
      2'b01:   dmem.dmem_wdata = {2{wdata_q[15:0]}};
      default: dmem.dmem_wdata = wdata_q;
    endcase
    if (!in_bus) begin
      dmem.dmem_be = 4'b0000;
    end else if (!we_q) begin
      dmem.dmem_be = 4'b1111;
    end else begin
      case (ldsel_q[1:0])
        2'b00:   dmem.dmem_be = 4'b0001 << addr_q[1:0];
        2'b01:   dmem.dmem_be = addr_q[1] ? 4'b1100 : 4'b0011;
        default: dmem.dmem_be = 4'b1111;
      endcase
    end
  end

  // Move the addressed byte/half down to bit 0 before extending.
  assign rd_lane = 16'(dmem.dmem_rdata >> {addr_q[1:0], 3'b000});

  always_comb begin
    case (ldsel_q)
      3'b000:  load_fmt = {{24{rd_lane[7]}}, rd_lane[7:0]};
      3'b001:  load_fmt = {{16{rd_lane[15]}}, rd_lane};
      3'b100:  load_fmt = {24'd0, rd_lane[7:0]};
      3'b101:  load_fmt = {16'd0, rd_lane};
      default: load_fmt = dmem.dmem_rdata;
    endcase
  end

  assign stall      = accept || in_bus;
  assign load_valid = (state == DONE) && !we_q && !timeout_q;
  assign bus_err    = (state == DONE) && timeout_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized bench: a cycle-indexed expectation table, filled from per-access timing arithmetic,
// is checked against the DUT every cycle; directed accesses pin key values with literals.
module tb_dmem_access_unit;
  localparam int MW   = 4;
  localparam int NCYC = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_we;
  logic [2:0]  LdSel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        bus_err;

  dmem_access_unit_if bus();

  dmem_access_unit #(.MAX_WAIT(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .LdSel      (LdSel),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .dmem       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit          exp_req   [NCYC];
  bit          exp_stall [NCYC];
  bit          exp_lv    [NCYC];
  bit          exp_mis   [NCYC];
  bit          exp_berr  [NCYC];
  bit          exp_we    [NCYC];
  bit          exp_chkwd [NCYC];
  bit          exp_ldupd [NCYC];
  logic [3:0]  exp_be    [NCYC];
  logic [31:0] exp_addr  [NCYC];
  logic [31:0] exp_wd    [NCYC];
  logic [31:0] exp_ldval [NCYC];

  logic [31:0] cur_ld;
  bit          chk_en = 1'b0;

  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic        s_mis;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] code, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*off +: 8];
    h = rd[16*off[1] +: 16];
    case (code)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      if (exp_ldupd[cyc]) cur_ld = exp_ldval[cyc];
      chk("stall",      32'(stall),       32'(exp_stall[cyc]));
      chk("dmem_req",   32'(bus.dmem_req), 32'(exp_req[cyc]));
      chk("load_valid", 32'(load_valid),  32'(exp_lv[cyc]));
      chk("misalign",   32'(misalign),    32'(exp_mis[cyc]));
      chk("bus_err",    32'(bus_err),     32'(exp_berr[cyc]));
      chk("load_data",  load_data,        cur_ld);
      if (exp_req[cyc]) begin
        chk("dmem_we",   32'(bus.dmem_we), 32'(exp_we[cyc]));
        chk("dmem_be",   32'(bus.dmem_be), 32'(exp_be[cyc]));
        chk("dmem_addr", bus.dmem_addr,    exp_addr[cyc]);
        if (exp_chkwd[cyc]) chk("dmem_wdata", bus.dmem_wdata, exp_wd[cyc]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      mem_valid = 1'b0;
      bus.dmem_ready = 1'($urandom_range(0, 1));
      bus.dmem_rdata = $urandom;
      tick();
    end
    mem_valid = 1'b0;
  endtask

  // w = WAIT cycles before ready (0 = ready in REQ); w > MW never readies; rst_mid resets in WAIT #2.
  task automatic do_access(input bit we, input logic [2:0] code, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int w,
                           input bit rst_mid);
    int n, nw, idx;
    bit legal, algn, tout;
    logic [3:0]  be;
    logic [31:0] wexp;
    n     = cyc;
    legal = (code inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (code[1:0])
      2'b01:   algn = (a[0] == 1'b0);
      2'b10:   algn = (a[1:0] == 2'b00);
      default: algn = 1'b1;
    endcase
    mem_valid = 1'b1; mem_we = we; LdSel = code; addr = a; wdata = wd;
    bus.dmem_ready = 1'($urandom_range(0, 1));
    bus.dmem_rdata = $urandom;
    if (!(legal && algn)) begin
      exp_mis[n] = 1'b1;
      @(negedge clk);
      s_mis = misalign;
      tick();
      mem_valid = 1'b0;
      return;
    end
    if (!we) begin
      be = 4'b1111; wexp = wd;
    end else begin
      case (code[1:0])
        2'b00:   begin be = 4'(1 << a[1:0]);           wexp = {4{wd[7:0]}};  end
        2'b01:   begin be = a[1] ? 4'b1100 : 4'b0011; wexp = {2{wd[15:0]}}; end
        default: begin be = 4'b1111;                  wexp = wd;            end
      endcase
    end
    tout = (w > MW) && !rst_mid;
    nw   = rst_mid ? 2 : (tout ? MW : w);
    exp_stall[n] = 1'b1;
    for (int k = 0; k <= nw; k++) begin
      idx = n + 1 + k;
      exp_req[idx] = 1'b1; exp_stall[idx] = 1'b1; exp_we[idx] = we; exp_be[idx] = be;
      exp_addr[idx] = {a[31:2], 2'b00}; exp_wd[idx] = wexp; exp_chkwd[idx] = we;
    end
    if (rst_mid) begin
      exp_ldupd[n+4] = 1'b1; exp_ldval[n+4] = 32'd0;
    end else begin
      idx = n + 2 + nw;
      exp_lv[idx]   = !we && !tout;
      exp_berr[idx] = tout;
      if (tout) begin
        exp_ldupd[idx] = 1'b1; exp_ldval[idx] = 32'd0;
      end else if (!we) begin
        exp_ldupd[idx] = 1'b1; exp_ldval[idx] = model_load(code, a[1:0], rd);
      end
    end
    @(negedge clk);
    s_mis = misalign;
    tick();
    for (int k = 0; k <= nw; k++) begin
      mem_valid = 1'($urandom_range(0, 1)); mem_we = 1'($urandom_range(0, 1));
      LdSel = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
      bus.dmem_ready = !tout && !rst_mid && (k == w);
      bus.dmem_rdata = (k == w) ? rd : $urandom;
      if (rst_mid && k == 2) rst = 1'b1;
      @(negedge clk);
      if (k == 0) begin
        s_addr = bus.dmem_addr; s_wdata = bus.dmem_wdata; s_be = bus.dmem_be;
      end
      tick();
    end
    if (rst_mid) begin
      rst = 1'b0; mem_valid = 1'b0; bus.dmem_ready = 1'b0;
      return;
    end
    mem_valid = 1'($urandom_range(0, 1)); LdSel = 3'($urandom_range(0, 7)); addr = $urandom;
    bus.dmem_ready = 1'($urandom_range(0, 1)); bus.dmem_rdata = $urandom;
    tick();
    mem_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ldc [5];
    logic [2:0] ill [3];
    logic [2:0] code;
    logic [31:0] a;
    bit we;
    ldc = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    ill = '{3'b011, 3'b110, 3'b111};

    rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; LdSel = 3'b000; addr = 32'd0; wdata = 32'd0;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = 32'd0;
    exp_ldupd[1] = 1'b1; exp_ldval[1] = 32'd0;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_dmem_addr",  bus.dmem_addr,      32'd0);
    chk("rst_dmem_wdata", bus.dmem_wdata,     32'd0);
    chk("rst_dmem_be",    32'(bus.dmem_be),   32'd0);
    chk("rst_dmem_we",    32'(bus.dmem_we),   32'd0);
    tick();
    rst = 1'b0;
    idle(2);

    do_access(1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'h80AA55CC, 0, 1'b0);
    @(negedge clk); chk("lbu_data", load_data, 32'h0000_0080); tick();

    do_access(1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'hF00D1234, 3, 1'b0);
    @(negedge clk); chk("lh_data", load_data, 32'hFFFF_F00D); tick();

    do_access(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'hDEAD_BEEF, 1, 1'b0);
    chk("sb_wdata", s_wdata, 32'hABAB_ABAB);
    chk("sb_be",    32'(s_be), 32'h2);
    chk("sb_addr",  s_addr,  32'h0000_3000);
    @(negedge clk); chk("sb_keeps_load_data", load_data, 32'hFFFF_F00D); tick();

    do_access(1'b0, 3'b010, 32'h0000_4002, 32'd0, 32'd0, 0, 1'b0);
    chk("lw_misalign", 32'(s_mis), 32'd1);
    idle(1);

    do_access(1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'h1111_1111, MW + 1, 1'b0);
    @(negedge clk); chk("timeout_data", load_data, 32'd0); tick();

    do_access(1'b0, 3'b010, 32'h0000_6000, 32'd0, 32'h5555_5555, 99, 1'b1);
    @(negedge clk);
    chk("rst_mid_req",  32'(bus.dmem_req), 32'd0);
    chk("rst_mid_addr", bus.dmem_addr,     32'd0);
    tick();
    do_access(1'b0, 3'b010, 32'h0000_6004, 32'd0, 32'h1234_5678, 1, 1'b0);
    @(negedge clk); chk("after_rst_lw", load_data, 32'h1234_5678); tick();

    do_access(1'b0, 3'b000, 32'h0000_7002, 32'd0, 32'h0091_0000, MW, 1'b0);
    @(negedge clk); chk("lb_last_wait", load_data, 32'hFFFF_FF91); tick();

    for (int t = 0; t < 220 && cyc < NCYC - 40; t++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) code = ill[$urandom_range(0, 2)];
      else if (we)                   code = 3'($urandom_range(0, 2));
      else                           code = ldc[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (code[1:0] == 2'b01) a[0] = 1'b0;
        if (code[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      do_access(we, code, a, $urandom, $urandom, $urandom_range(0, MW + 1), 1'b0);
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
